// File: rtl/pcs_tx_encoder_pkg.sv
// Shared constants for the 10GBASE-R transmit encoder: block-type codes,
// XGMII characters, 7-bit control codes and the fixed error/fault blocks.
// Latency: n/a (package). Backpressure: n/a.
package pcs_tx_pkg;

  // Block classification codes, shared with the receive-side classifier
  typedef enum logic [2:0] {
    TT_S = 3'b000,
    TT_C = 3'b001,
    TT_E = 3'b010,
    TT_D = 3'b011,
    TT_T = 3'b100
  } t_type_t;

  typedef enum logic [2:0] {
    TX_INIT = 3'd0,
    TX_C    = 3'd1,
    TX_D    = 3'd2,
    TX_T    = 3'd3,
    TX_E    = 3'd4
  } tx_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_OS    = 8'h4B;
  localparam logic [7:0] BT_START = 8'h78;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_ERROR = 8'hFE;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_SEQ   = 8'h9C;

  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  // Every lane carries the error control code
  localparam logic [65:0] EBLOCK_T = {{8{CC_ERROR}}, BT_IDLE, SYNC_CTRL};
  // Local-fault ordered set: D1=00, D2=00, D3=01, O=0
  localparam logic [65:0] LBLOCK_T = {28'h0, 4'h0, 8'h01, 8'h00, 8'h00, BT_OS, SYNC_CTRL};

  // Block type byte for a terminate in lane k
  function automatic logic [7:0] term_block_type(input logic [2:0] k);
    logic [7:0] bt;
    case (k)
      3'd0:    bt = 8'h87;
      3'd1:    bt = 8'h99;
      3'd2:    bt = 8'hAA;
      3'd3:    bt = 8'hB4;
      3'd4:    bt = 8'hCC;
      3'd5:    bt = 8'hD2;
      3'd6:    bt = 8'hE1;
      default: bt = 8'hFF;
    endcase
    return bt;
  endfunction

endpackage

// File: rtl/pcs_tx_encoder_t_type.sv
// Combinational XGMII word classifier (S/C/E/D/T) with terminate lane index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, the caller decides whether to use it.
// Ports: txd/txc = XGMII word; blk_type = class; term_lane = lane holding Terminate (valid for TT_T).
module t_type
  import pcs_tx_pkg::*;
(
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output t_type_t     blk_type,
  output logic [2:0]  term_lane
);

  logic [7:0] lane_idle;
  logic [7:0] lane_ctl_ok;

  always_comb begin
    lane_idle   = '0;
    lane_ctl_ok = '0;
    for (int i = 0; i < 8; i++) begin
      lane_idle[i]   = (txd[8*i +: 8] == CH_IDLE);
      lane_ctl_ok[i] = (txd[8*i +: 8] == CH_IDLE) || (txd[8*i +: 8] == CH_ERROR);
    end
  end

  always_comb begin
    logic [7:0] t_mask;
    logic [7:0] k_bit;
    blk_type  = TT_E;
    term_lane = '0;
    t_mask    = '0;
    k_bit     = '0;
    if (txc == 8'h00) begin
      blk_type = TT_D;
    end else if (txc == 8'hFF && (&lane_idle)) begin
      blk_type = TT_C;
    end else if (txc == 8'hF1 && txd[7:0] == CH_SEQ && (&lane_idle[7:4])) begin
      blk_type = TT_C;
    end else if (txc == 8'h01 && txd[7:0] == CH_START) begin
      blk_type = TT_S;
    end else begin
      // Terminate in lane k needs control flags exactly on lanes k..7, and
      // every control lane above k must be Idle or Error.
      for (int k = 0; k < 8; k++) begin
        t_mask = 8'hFF << k;
        k_bit  = 8'h01 << k;
        if (txc == t_mask && txd[8*k +: 8] == CH_TERM &&
            (&(lane_ctl_ok | ~txc | k_bit))) begin
          blk_type  = TT_T;
          term_lane = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pcs_tx_encoder.sv
// 10GBASE-R PCS transmit encoder: classify XGMII word, run TX FSM, emit 66-bit block.
// Latency: 1 cycle from accepted word to registered block.
// Backpressure: in_valid=0 stalls; state, block and error count hold, out_valid drops.
// Ports: clk/reset; txd_in/txc_in XGMII word; in_valid pacing; tx_lf local fault;
//        encoder_out block; out_valid; tx_err_cnt saturating EBLOCK_T count.
module pcs_tx_encoder
  import pcs_tx_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          txd_in,
  input  logic [7:0]           txc_in,
  input  logic                 in_valid,
  input  logic                 tx_lf,
  output logic [65:0]          encoder_out,
  output logic                 out_valid,
  output logic [ERR_CNT_W-1:0] tx_err_cnt
);

  t_type_t     typ;
  logic [2:0]  term;
  tx_state_t   state;
  tx_state_t   nxt;
  logic [65:0] enc;

  t_type u_t_type (
    .txd      (txd_in),
    .txc      (txc_in),
    .blk_type (typ),
    .term_lane(term)
  );

  always_comb begin
    nxt = TX_E;
    case (state)
      TX_INIT, TX_C, TX_T: begin
        if (typ == TT_C)      nxt = TX_C;
        else if (typ == TT_S) nxt = TX_D;
        else                  nxt = TX_E;
      end
      TX_D: begin
        if (typ == TT_D)      nxt = TX_D;
        else if (typ == TT_T) nxt = TX_T;
        else                  nxt = TX_E;
      end
      TX_E: begin
        case (typ)
          TT_D, TT_S: nxt = TX_D;
          TT_C:       nxt = TX_C;
          TT_T:       nxt = TX_T;
          default:    nxt = TX_E;
        endcase
      end
      default: nxt = TX_E;
    endcase
  end

  always_comb begin
    enc = EBLOCK_T;
    case (typ)
      TT_D: enc = {txd_in, SYNC_DATA};
      TT_C: begin
        if (txc_in == 8'hFF) enc = {{8{CC_IDLE}}, BT_IDLE, SYNC_CTRL};
        else                 enc = {28'h0, 4'h0, txd_in[31:8], BT_OS, SYNC_CTRL};
      end
      TT_S: enc = {txd_in[63:8], BT_START, SYNC_CTRL};
      TT_T: begin
        // Data lanes pack from bit 10; lanes after the terminate keep their
        // 7-bit positions, leaving a 7-k bit zero pad in between.
        enc      = '0;
        enc[1:0] = SYNC_CTRL;
        enc[9:2] = term_block_type(term);
        for (int i = 0; i < 7; i++) begin
          if (i < int'(term)) enc[10+8*i +: 8] = txd_in[8*i +: 8];
        end
        for (int j = 1; j < 8; j++) begin
          if (j > int'(term))
            enc[10+7*j +: 7] = (txd_in[8*j +: 8] == CH_ERROR) ? CC_ERROR : CC_IDLE;
        end
      end
      default: enc = EBLOCK_T;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= TX_INIT;
      encoder_out <= LBLOCK_T;
      out_valid   <= 1'b0;
      tx_err_cnt  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (tx_lf) begin
          state       <= TX_INIT;
          encoder_out <= LBLOCK_T;
        end else begin
          state <= nxt;
          if (nxt == TX_E) begin
            encoder_out <= EBLOCK_T;
            if (tx_err_cnt != '1) tx_err_cnt <= tx_err_cnt + ERR_CNT_W'(1);
          end else begin
            encoder_out <= enc;
          end
        end
      end
    end
  end

endmodule
